// File: rtl/mybul_app.sv
// Player bullet controller: launches from the tank, advances one cell per move tick,
// reports the lowest-numbered live enemy it strikes, then holds off re-arming for a cool-down.
module mybul_app #(
   parameter int         X_MAX      = 16,
   parameter int         Y_MAX      = 20,
   parameter int         COOL_TICKS = 2,
   parameter logic [4:0] PARK       = 5'd31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_en,
   input  logic       move_tick,
   input  logic       bul_sht,
   input  logic [1:0] tank_dir_in,
   input  logic [4:0] tank_x_in,
   input  logic [4:0] tank_y_in,
   input  logic [4:0] en1_x,
   input  logic [4:0] en2_x,
   input  logic [4:0] en3_x,
   input  logic [4:0] en4_x,
   input  logic [4:0] en1_y,
   input  logic [4:0] en2_y,
   input  logic [4:0] en3_y,
   input  logic [4:0] en4_y,
   input  logic [3:0] en_alive,
   output logic [4:0] bul_x,
   output logic [4:0] bul_y,
   output logic       mybul_state_feedback,
   output logic [1:0] bul_dir,
   output logic [3:0] hit_pulse
);

   localparam int CW = (COOL_TICKS < 2) ? 1 : $clog2(COOL_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_FLY, S_END, S_COOL} state_t;

   state_t        state_q;
   logic [4:0]    x_q, y_q;
   logic          fb_q;
   logic [1:0]    dir_q;
   logic [3:0]    hit_q;
   logic [CW-1:0] cnt_q;

   logic [3:0]    match;
   logic [3:0]    hit_sel;
   logic [4:0]    nxt_x, nxt_y;

   // True when one more step in dir would leave the playfield.
   function automatic logic at_edge(input logic [1:0] dir, input logic [4:0] x, input logic [4:0] y);
      case (dir)
         2'b00:   at_edge = (y == 5'd0);
         2'b01:   at_edge = (y >= 5'(Y_MAX));
         2'b10:   at_edge = (x == 5'd0);
         default: at_edge = (x >= 5'(X_MAX));
      endcase
   endfunction

   always_comb begin
      match[0] = en_alive[0] && (en1_x == x_q) && (en1_y == y_q);
      match[1] = en_alive[1] && (en2_x == x_q) && (en2_y == y_q);
      match[2] = en_alive[2] && (en3_x == x_q) && (en3_y == y_q);
      match[3] = en_alive[3] && (en4_x == x_q) && (en4_y == y_q);
      hit_sel  = match & (~match + 4'd1);
   end

   always_comb begin
      nxt_x = x_q;
      nxt_y = y_q;
      case (dir_q)
         2'b00:   nxt_y = y_q - 5'd1;
         2'b01:   nxt_y = y_q + 5'd1;
         2'b10:   nxt_x = x_q - 5'd1;
         default: nxt_x = x_q + 5'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= PARK;
         y_q     <= PARK;
         fb_q    <= 1'b0;
         dir_q   <= 2'b00;
         hit_q   <= 4'b0000;
         cnt_q   <= '0;
      end else if (!game_en) begin
         state_q <= S_IDLE;
         x_q     <= PARK;
         y_q     <= PARK;
         fb_q    <= 1'b0;
         hit_q   <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         hit_q <= 4'b0000;
         case (state_q)
            S_IDLE: begin
               if (bul_sht) begin
                  x_q     <= tank_x_in;
                  y_q     <= tank_y_in;
                  dir_q   <= tank_dir_in;
                  fb_q    <= 1'b1;
                  state_q <= S_FLY;
               end
            end
            S_FLY: begin
               // A hit freezes the bullet on the struck cell even if a tick arrives.
               if (|match) begin
                  hit_q   <= hit_sel;
                  state_q <= S_END;
               end else if (move_tick) begin
                  if (at_edge(dir_q, x_q, y_q)) begin
                     state_q <= S_END;
                  end else begin
                     x_q <= nxt_x;
                     y_q <= nxt_y;
                  end
               end
            end
            S_END: begin
               x_q     <= PARK;
               y_q     <= PARK;
               fb_q    <= 1'b0;
               cnt_q   <= CW'(COOL_TICKS);
               state_q <= (COOL_TICKS == 0) ? S_IDLE : S_COOL;
            end
            S_COOL: begin
               if (move_tick) begin
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q <= CW'(1)) state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bul_x                = x_q;
   assign bul_y                = y_q;
   assign mybul_state_feedback = fb_q;
   assign bul_dir              = dir_q;
   assign hit_pulse            = hit_q;

endmodule

// File: tb/tb_mybul_app.sv
// Bench for mybul_app: directed scenarios with fixed expectations, then a randomized
// run compared cycle by cycle against an integer-coordinate behavioural model.
module tb_mybul_app;

   localparam int         X_MAX      = 16;
   localparam int         Y_MAX      = 20;
   localparam int         COOL_TICKS = 2;
   localparam logic [4:0] PARK       = 5'd31;

   logic       clk = 1'b0;
   logic       rst, game_en, move_tick, bul_sht;
   logic [1:0] tank_dir_in;
   logic [4:0] tank_x_in, tank_y_in;
   logic [4:0] ex [4];
   logic [4:0] ey [4];
   logic [3:0] en_alive;
   logic [4:0] bul_x, bul_y;
   logic       fb;
   logic [1:0] bul_dir;
   logic [3:0] hit_pulse;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_x, m_y, m_dir, m_fb, m_hit, m_cnt;
   bit m_fly, m_end, m_cool;

   always #5 clk = ~clk;

   mybul_app #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .COOL_TICKS(COOL_TICKS), .PARK(PARK)) dut (
      .clk(clk), .rst(rst), .game_en(game_en), .move_tick(move_tick), .bul_sht(bul_sht),
      .tank_dir_in(tank_dir_in), .tank_x_in(tank_x_in), .tank_y_in(tank_y_in),
      .en1_x(ex[0]), .en2_x(ex[1]), .en3_x(ex[2]), .en4_x(ex[3]),
      .en1_y(ey[0]), .en2_y(ey[1]), .en3_y(ey[2]), .en4_y(ey[3]),
      .en_alive(en_alive), .bul_x(bul_x), .bul_y(bul_y),
      .mybul_state_feedback(fb), .bul_dir(bul_dir), .hit_pulse(hit_pulse)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic to_idle();
      game_en = 1'b0; move_tick = 1'b0; bul_sht = 1'b0;
      cyc();
      game_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; game_en = 1'b1; move_tick = 1'b1; bul_sht = 1'b1;
      tank_dir_in = 2'b11; tank_x_in = 5'd4; tank_y_in = 5'd4; en_alive = 4'b0000;
      for (int k = 0; k < 4; k++) begin ex[k] = 5'd0; ey[k] = 5'd0; end
      cyc();
      checks++; if (bul_x !== PARK || bul_y !== PARK) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) want (31,31)", bul_x, bul_y); end
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL reset_fb: got %b want 0", fb); end
      checks++; if (bul_dir !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b want 00", bul_dir); end
      checks++; if (hit_pulse !== 4'b0000) begin errors++; $display("FAIL reset_hit: got %b want 0000", hit_pulse); end
      rst = 1'b0; bul_sht = 1'b0; move_tick = 1'b0;
      cyc();
      checks++; if (fb !== 1'b0 || bul_x !== PARK) begin errors++; $display("FAIL reset_idle: got fb=%b x=%0d want fb=0 x=31", fb, bul_x); end
   endtask

   task automatic test_fly_right();
      tank_x_in = 5'd7; tank_y_in = 5'd7; tank_dir_in = 2'b11; bul_sht = 1'b1;
      cyc();
      bul_sht = 1'b0;
      checks++; if (fb !== 1'b1 || bul_x !== 5'd7 || bul_y !== 5'd7 || bul_dir !== 2'b11) begin
         errors++; $display("FAIL fly_launch: got fb=%b (%0d,%0d) dir=%b want fb=1 (7,7) dir=11", fb, bul_x, bul_y, bul_dir); end
      for (int i = 1; i <= 9; i++) begin
         move_tick = 1'b1; cyc(); move_tick = 1'b0; cyc();
         checks++; if (bul_x !== 5'(7 + i) || bul_y !== 5'd7) begin
            errors++; $display("FAIL fly_step%0d: got (%0d,%0d) want (%0d,7)", i, bul_x, bul_y, 7 + i); end
      end
      move_tick = 1'b1; cyc(); move_tick = 1'b0;
      checks++; if (bul_x !== 5'd16 || fb !== 1'b1) begin errors++; $display("FAIL fly_end: got x=%0d fb=%b want x=16 fb=1", bul_x, fb); end
      cyc();
      checks++; if (bul_x !== PARK || bul_y !== PARK || fb !== 1'b0) begin
         errors++; $display("FAIL fly_park: got (%0d,%0d) fb=%b want (31,31) fb=0", bul_x, bul_y, fb); end
      to_idle();
   endtask

   task automatic test_edge_left();
      tank_x_in = 5'd0; tank_y_in = 5'd6; tank_dir_in = 2'b10; bul_sht = 1'b1; move_tick = 1'b1;
      cyc();
      bul_sht = 1'b0;
      checks++; if (bul_x !== 5'd0 || fb !== 1'b1) begin errors++; $display("FAIL left_launch: got x=%0d fb=%b want x=0 fb=1", bul_x, fb); end
      cyc();
      move_tick = 1'b0;
      checks++; if (bul_x !== 5'd0 || bul_y !== 5'd6 || fb !== 1'b1) begin
         errors++; $display("FAIL left_end: got (%0d,%0d) fb=%b want (0,6) fb=1", bul_x, bul_y, fb); end
      cyc();
      checks++; if (bul_x !== PARK || fb !== 1'b0) begin errors++; $display("FAIL left_park: got x=%0d fb=%b want x=31 fb=0", bul_x, fb); end
      to_idle();
   endtask

   task automatic test_hit();
      en_alive = 4'b0010; ex[1] = 5'd3; ey[1] = 5'd2;
      tank_x_in = 5'd3; tank_y_in = 5'd5; tank_dir_in = 2'b00; bul_sht = 1'b1;
      cyc();
      bul_sht = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         move_tick = 1'b1; cyc(); move_tick = 1'b0;
         checks++; if (bul_y !== 5'(5 - i) || hit_pulse !== 4'b0000) begin
            errors++; $display("FAIL hit_step%0d: got y=%0d hit=%b want y=%0d hit=0000", i, bul_y, hit_pulse, 5 - i); end
         if (i < 3) cyc();
      end
      cyc();
      checks++; if (hit_pulse !== 4'b0010 || bul_x !== 5'd3 || bul_y !== 5'd2) begin
         errors++; $display("FAIL hit_pulse: got hit=%b (%0d,%0d) want hit=0010 (3,2)", hit_pulse, bul_x, bul_y); end
      cyc();
      checks++; if (hit_pulse !== 4'b0000 || bul_x !== PARK || fb !== 1'b0) begin
         errors++; $display("FAIL hit_after: got hit=%b x=%0d fb=%b want hit=0000 x=31 fb=0", hit_pulse, bul_x, fb); end
      en_alive = 4'b0000;
      to_idle();
   endtask

   task automatic test_multi_hit();
      logic [3:0] alive_tab [2];
      logic [3:0] want_tab [2];
      alive_tab[0] = 4'b0101; want_tab[0] = 4'b0001;
      alive_tab[1] = 4'b1010; want_tab[1] = 4'b0010;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 4; k++) begin ex[k] = 5'd5; ey[k] = 5'd10; end
         en_alive = alive_tab[c];
         tank_x_in = 5'd5; tank_y_in = 5'd10; tank_dir_in = 2'b11; bul_sht = 1'b1;
         cyc();
         bul_sht = 1'b0; move_tick = 1'b1;
         cyc();
         move_tick = 1'b0;
         checks++; if (hit_pulse !== want_tab[c] || bul_x !== 5'd5 || bul_y !== 5'd10) begin
            errors++; $display("FAIL multi_hit%0d: got hit=%b (%0d,%0d) want hit=%b (5,10)", c, hit_pulse, bul_x, bul_y, want_tab[c]); end
         en_alive = 4'b0000;
         to_idle();
      end
   endtask

   task automatic test_cool_relaunch();
      en_alive = 4'b0000;
      tank_x_in = 5'd2; tank_y_in = 5'd19; tank_dir_in = 2'b01; bul_sht = 1'b1;
      cyc();
      move_tick = 1'b1; cyc(); move_tick = 1'b0;
      checks++; if (bul_y !== 5'd20) begin errors++; $display("FAIL cool_step: got y=%0d want 20", bul_y); end
      move_tick = 1'b1; cyc(); move_tick = 1'b0;
      checks++; if (bul_y !== 5'd20 || fb !== 1'b1) begin errors++; $display("FAIL cool_end: got y=%0d fb=%b want y=20 fb=1", bul_y, fb); end
      cyc();
      checks++; if (fb !== 1'b0 || bul_y !== PARK) begin errors++; $display("FAIL cool_park: got y=%0d fb=%b want y=31 fb=0", bul_y, fb); end
      cyc();
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL cool_wait0: got fb=%b want 0", fb); end
      move_tick = 1'b1; cyc(); move_tick = 1'b0;
      cyc();
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL cool_wait1: got fb=%b want 0", fb); end
      move_tick = 1'b1; cyc(); move_tick = 1'b0;
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL cool_idle: got fb=%b want 0", fb); end
      cyc();
      checks++; if (fb !== 1'b1 || bul_x !== 5'd2 || bul_y !== 5'd19 || bul_dir !== 2'b01) begin
         errors++; $display("FAIL cool_relaunch: got fb=%b (%0d,%0d) dir=%b want fb=1 (2,19) dir=01", fb, bul_x, bul_y, bul_dir); end
      to_idle();
   endtask

   task automatic test_abort();
      en_alive = 4'b0001; ex[0] = 5'd10; ey[0] = 5'd4;
      tank_x_in = 5'd10; tank_y_in = 5'd4; tank_dir_in = 2'b10; bul_sht = 1'b1;
      cyc();
      bul_sht = 1'b0; game_en = 1'b0;
      cyc();
      game_en = 1'b1;
      checks++; if (bul_x !== PARK || bul_y !== PARK || fb !== 1'b0 || hit_pulse !== 4'b0000 || bul_dir !== 2'b10) begin
         errors++; $display("FAIL abort_gen: got (%0d,%0d) fb=%b hit=%b dir=%b want (31,31) fb=0 hit=0000 dir=10", bul_x, bul_y, fb, hit_pulse, bul_dir); end
      bul_sht = 1'b1;
      cyc();
      bul_sht = 1'b0;
      checks++; if (fb !== 1'b1 || bul_x !== 5'd10) begin errors++; $display("FAIL abort_gen_idle: got fb=%b x=%0d want fb=1 x=10", fb, bul_x); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++; if (bul_x !== PARK || bul_y !== PARK || fb !== 1'b0 || hit_pulse !== 4'b0000 || bul_dir !== 2'b00) begin
         errors++; $display("FAIL abort_rst: got (%0d,%0d) fb=%b hit=%b dir=%b want (31,31) fb=0 hit=0000 dir=00", bul_x, bul_y, fb, hit_pulse, bul_dir); end
      en_alive = 4'b0000; bul_sht = 1'b1;
      cyc();
      bul_sht = 1'b0;
      checks++; if (fb !== 1'b1) begin errors++; $display("FAIL abort_rst_idle: got fb=%b want 1", fb); end
      to_idle();
   endtask

   task automatic model_step();
      int k, nx, ny;
      if (rst) begin
         m_fly = 0; m_end = 0; m_cool = 0; m_cnt = 0;
         m_x = PARK; m_y = PARK; m_fb = 0; m_dir = 0; m_hit = 0;
      end else if (!game_en) begin
         m_fly = 0; m_end = 0; m_cool = 0; m_cnt = 0;
         m_x = PARK; m_y = PARK; m_fb = 0; m_hit = 0;
      end else begin
         m_hit = 0;
         if (m_end) begin
            m_end = 0; m_x = PARK; m_y = PARK; m_fb = 0;
            m_cnt = COOL_TICKS; m_cool = (COOL_TICKS > 0);
         end else if (m_cool) begin
            if (move_tick) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_cool = 0;
            end
         end else if (m_fly) begin
            k = -1;
            for (int e = 3; e >= 0; e--)
               if (en_alive[e] && int'(ex[e]) == m_x && int'(ey[e]) == m_y) k = e;
            if (k >= 0) begin
               m_hit = 1 << k; m_fly = 0; m_end = 1;
            end else if (move_tick) begin
               nx = m_x; ny = m_y;
               case (m_dir)
                  0: ny = m_y - 1;
                  1: ny = m_y + 1;
                  2: nx = m_x - 1;
                  default: nx = m_x + 1;
               endcase
               if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
                  m_fly = 0; m_end = 1;
               end else begin
                  m_x = nx; m_y = ny;
               end
            end
         end else if (bul_sht) begin
            m_x = tank_x_in; m_y = tank_y_in; m_dir = tank_dir_in; m_fb = 1; m_fly = 1;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         rst         = (n == 0) || ($urandom_range(199) == 0);
         game_en     = ($urandom_range(49) != 0);
         move_tick   = ($urandom_range(2) == 0);
         bul_sht     = ($urandom_range(3) == 0);
         tank_dir_in = 2'($urandom_range(3));
         tank_x_in   = 5'($urandom_range(X_MAX));
         tank_y_in   = 5'($urandom_range(Y_MAX));
         en_alive    = 4'($urandom_range(15));
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(5) == 0) begin
               ex[k] = 5'(m_x); ey[k] = 5'(m_y);
            end else begin
               ex[k] = 5'($urandom_range(X_MAX)); ey[k] = 5'($urandom_range(Y_MAX));
            end
         end
         model_step();
         cyc();
         checks++; if (bul_x !== 5'(m_x) || bul_y !== 5'(m_y)) begin
            errors++; $display("FAIL rand_pos@%0d: got (%0d,%0d) want (%0d,%0d)", n, bul_x, bul_y, m_x, m_y); end
         checks++; if (fb !== 1'(m_fb)) begin errors++; $display("FAIL rand_fb@%0d: got %b want %0d", n, fb, m_fb); end
         checks++; if (bul_dir !== 2'(m_dir)) begin errors++; $display("FAIL rand_dir@%0d: got %b want %0d", n, bul_dir, m_dir); end
         checks++; if (hit_pulse !== 4'(m_hit)) begin errors++; $display("FAIL rand_hit@%0d: got %b want %b", n, hit_pulse, 4'(m_hit)); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fly_right();
      test_edge_left();
      test_hit();
      test_multi_hit();
      test_cool_relaunch();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mybul_app.md
MYBUL_APP -- requirements
Module: mybul_app

Interface
REQ-001 Parameter X_MAX, default 16: largest legal bullet x cell.
REQ-002 Parameter Y_MAX, default 20: largest legal bullet y cell.
REQ-003 Parameter COOL_TICKS, default 2: move ticks of re-arm delay after a bullet ends; 0 means no delay.
REQ-004 Parameter PARK, default 5'd31: off-field coordinate driven while no bullet is in flight.
REQ-005 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 game_en  input  1  game running; 0 aborts any bullet in flight.
REQ-008 move_tick  input  1  single-clk-cycle pulse; bullet advances one cell per pulse.
REQ-009 bul_sht  input  1  shoot request from the player tank, level-sensitive.
REQ-010 tank_dir_in  input  2  tank heading: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-011 tank_x_in / tank_y_in  input  5 each  tank cell at launch.
REQ-012 en1_x..en4_x, en1_y..en4_y  input  5 each  enemy tank cells.
REQ-013 en_alive  input  4  bit i-1 = enemy i alive; dead enemies are never hit.
REQ-014 bul_x / bul_y  output  5 each  bullet cell, PARK when inactive.
REQ-015 mybul_state_feedback  output  1  1 while the bullet is in flight, fed back to the tank.
REQ-016 bul_dir  output  2  latched flight direction.
REQ-017 hit_pulse  output  4  one-hot, one-cycle pulse naming the enemy struck.

Function
REQ-018 The FSM SHALL have states IDLE, FLY, END and COOL; all outputs are registered.
REQ-019 IDLE: bul_x = bul_y = PARK and feedback = 0.
REQ-020 IDLE with bul_sht=1 and game_en=1: the next edge SHALL load bul_x/bul_y from tank_x_in/tank_y_in and bul_dir from tank_dir_in, set feedback=1 and go to FLY.
REQ-021 Launch SHALL take exactly one cycle from the sampled request; a move_tick on the launch edge SHALL NOT move the bullet.
REQ-022 FLY hit check: every cycle, if any enemy i with en_alive[i-1]=1 has en_x=bul_x and en_y=bul_y, the next edge SHALL assert hit_pulse[i-1] for one cycle and go to END.
REQ-023 Several simultaneous matches SHALL report only the lowest-numbered enemy.
REQ-024 FLY move: on move_tick with no hit, if the next cell is out of range the FSM SHALL go to END without moving.
REQ-025 Out of range means y=0 for up, y=Y_MAX for down, x=0 for left, x=X_MAX for right.
REQ-026 Otherwise move_tick SHALL step exactly one cell in bul_dir; coordinates SHALL never wrap.
REQ-027 A hit and a move_tick in the same cycle: the hit wins and the position is not updated.
REQ-028 END, one cycle: the edge leaving END SHALL park the bullet, clear feedback and load the cool counter with COOL_TICKS.
REQ-029 END exits to COOL, or to IDLE when COOL_TICKS=0.
REQ-030 COOL: the counter decrements on each move_tick; the FSM goes to IDLE on the edge where it reaches 0.
REQ-031 bul_sht is ignored in FLY, END and COOL.
REQ-032 The tank holds bul_sht=1 during flight, so a held request after IDLE is re-entered SHALL launch a new bullet.
REQ-033 game_en=0 in any state SHALL force IDLE at the next edge: bullet parked, feedback=0, counter cleared, no hit_pulse.
REQ-034 bul_dir SHALL hold its value outside launch.

Reset
REQ-035 rst=1 SHALL, at the next edge, set: state IDLE, bul_x = bul_y = PARK, feedback 0, bul_dir 00, hit_pulse 0, counter 0.
REQ-036 Reset SHALL take priority over all inputs, including during FLY or COOL.
REQ-037 No launch SHALL occur on the edge where rst is sampled high.

Verification
REQ-038 Tank (7,7), dir 11, bul_sht pulse, then 9 move_ticks, no enemies -> feedback=1 one cycle after the request; x = 8..16; the 10th tick gives END; bullet parks at 31; feedback=0.
REQ-039 Tank (3,5), dir 00, enemy2 alive at (3,2) -> after 3 ticks bul=(3,2); next edge hit_pulse=0010 for one cycle; park follows.
REQ-040 Enemies 1 and 3 both alive at the bullet cell, move_tick in the same cycle -> hit_pulse=0001 only; bul_x/bul_y unchanged on that edge.
REQ-041 bul_sht held high, COOL_TICKS=2 -> after END, exactly 2 move_ticks in COOL, then IDLE, then relaunch on the following edge.
REQ-042 rst or game_en=0 asserted mid-FLY at (10,4) -> next edge bul=(31,31), feedback=0, state IDLE, no hit_pulse.
REQ-043 Tank at x=0, dir 10, launch -> first move_tick ends the flight; bul_x never wraps to 31 through flight.
